// File: rtl/module_mux_display.sv
// ---------------------------------------------------------------------------
// module_mux_display
//
// Time-multiplexed driver for a 4-digit, common-anode 7-segment display.
// The four BCD digits coming from the binary-to-BCD converter are latched
// into a holding register whenever the converter flags them as valid. A
// refresh counter then sweeps a 2-bit digit index across units, tens,
// hundreds and thousands. Each digit stays lit for REFRESH_DIV clock cycles.
//
// Parameters
//   REFRESH_DIV    : clock cycles each digit stays lit (legal range 2..65535)
//
// Optional feature macro
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits from thousands
//                           down to tens are blanked. Their anode is still
//                           scanned. The units digit is always shown.
//
// Ports
//   clk            : system clock; all state changes on the rising edge
//   rst            : asynchronous, active-low reset
//   unidades_input : BCD units digit
//   decenas_input  : BCD tens digit
//   centenas_input : BCD hundreds digit
//   millares_input : BCD thousands digit
//   listo          : converter-done flag; the digits are valid while high
//   an_output      : anode enables, active-low; bit0 = units, bit3 = thousands
//   seg_output     : cathodes, active-low, ordered {g,f,e,d,c,b,a}
//
// Handshake
//   listo is a valid-only qualifier and has no ready. On every rising edge
//   where listo = 1, all four digits are captured. While listo = 0 the held
//   copy is kept. If listo stays high, the held copy tracks the inputs on
//   every cycle. A capture never disturbs the scan position or dwell count.
// ---------------------------------------------------------------------------
module module_mux_display #(
    parameter int REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] unidades_input,
    input  logic [3:0] decenas_input,
    input  logic [3:0] centenas_input,
    input  logic [3:0] millares_input,
    input  logic       listo,
    output logic [3:0] an_output,
    output logic [6:0] seg_output
);

    localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

    logic [3:0]  held_u;
    logic [3:0]  held_d;
    logic [3:0]  held_c;
    logic [3:0]  held_m;
    logic [15:0] refresh_cnt;
    logic [1:0]  digit_idx;

    logic [3:0]  digit_sel;
    logic        blank;
    logic [3:0]  an_next;
    logic [6:0]  seg_next;

    // Active-low decode in hex. Values 10..15 are not legal BCD, so they
    // show a dash (only segment g lit).
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    // Holding register, refresh counter and digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            held_u      <= '0;
            held_d      <= '0;
            held_c      <= '0;
            held_m      <= '0;
            refresh_cnt <= '0;
            digit_idx   <= '0;
        end else begin
            if (listo) begin
                held_u <= unidades_input;
                held_d <= decenas_input;
                held_c <= centenas_input;
                held_m <= millares_input;
            end
            // The wrap cycle of the counter moves the index. The 2-bit
            // index rolls from 3 back to 0 on its own.
            if (refresh_cnt == CNT_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 16'd1;
            end
        end
    end

    // Digit select and anode pattern for the current index.
    always_comb begin
        digit_sel = held_u;
        an_next   = 4'b1110;
        case (digit_idx)
            2'd0: begin digit_sel = held_u; an_next = 4'b1110; end
            2'd1: begin digit_sel = held_d; an_next = 4'b1101; end
            2'd2: begin digit_sel = held_c; an_next = 4'b1011; end
            2'd3: begin digit_sel = held_m; an_next = 4'b0111; end
            default: begin digit_sel = held_u; an_next = 4'b1110; end
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A slot is a leading zero when it and every more significant digit
    // are zero. The units slot is never blanked.
    always_comb begin
        blank = 1'b0;
        case (digit_idx)
            2'd3:    blank = (held_m == 4'd0);
            2'd2:    blank = (held_m == 4'd0) && (held_c == 4'd0);
            2'd1:    blank = (held_m == 4'd0) && (held_c == 4'd0) &&
                             (held_d == 4'd0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? 7'h7F : bcd_to_seg(digit_sel);

    // Output register. The pins see only flops. They are blank during reset
    // and follow index or held-digit changes one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_output  <= 4'hF;
            seg_output <= 7'h7F;
        end else begin
            an_output  <= an_next;
            seg_output <= seg_next;
        end
    end

endmodule

// File: tb/tb_module_mux_display.sv
module tb_module_mux_display;

    logic       clk;
    logic       rst;
    logic [3:0] unidades_input;
    logic [3:0] decenas_input;
    logic [3:0] centenas_input;
    logic [3:0] millares_input;
    logic       listo;
    logic [3:0] an_output;
    logic [6:0] seg_output;

    int n_cmp;
    int n_fail;

    logic [6:0] seg_tbl [0:15];
    logic [6:0] lz_seg;

    module_mux_display #(.REFRESH_DIV(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .unidades_input (unidades_input),
        .decenas_input  (decenas_input),
        .centenas_input (centenas_input),
        .millares_input (millares_input),
        .listo          (listo),
        .an_output      (an_output),
        .seg_output     (seg_output)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checks
    task automatic check(input string tag, input logic [3:0] an_exp,
                         input logic [6:0] seg_exp);
        n_cmp++;
        assert (an_output === an_exp) else begin
            n_fail++;
            $error("FAIL %s an_output: got %b expected %b", tag, an_output, an_exp);
        end
        n_cmp++;
        assert (seg_output === seg_exp) else begin
            n_fail++;
            $error("FAIL %s seg_output: got %h expected %h", tag, seg_output, seg_exp);
        end
    endtask

    // Wait n falling edges and check the outputs after each one.
    task automatic expect_run(input string tag, input logic [3:0] an_exp,
                              input logic [6:0] seg_exp, input int n);
        repeat (n) begin
            @(negedge clk);
            check(tag, an_exp, seg_exp);
        end
    endtask

    // Driver
    task automatic drive_digits(input logic [3:0] m, input logic [3:0] c,
                                input logic [3:0] d, input logic [3:0] u,
                                input logic l);
        millares_input = m;
        centenas_input = c;
        decenas_input  = d;
        unidades_input = u;
        listo          = l;
    endtask

    initial begin
        int found;
        n_cmp  = 0;
        n_fail = 0;
        seg_tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
        lz_seg = 7'h7F;
`else
        lz_seg = 7'h40;
`endif

        rst = 1'b0;
        drive_digits(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Reset state, including edges that occur while reset is held.
        expect_run("reset", 4'hF, 7'h7F, 2);

        // Release reset and pulse listo for one cycle with 1,2,3,4.
        rst = 1'b1;
        drive_digits(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
        expect_run("first_out", 4'b1110, 7'h40, 1);   // E1: held still 0
        listo = 1'b0;
        expect_run("scan_u", 4'b1110, 7'h19, 3);      // E2..E4
        expect_run("scan_d", 4'b1101, 7'h30, 4);      // E5..E8
        expect_run("scan_c", 4'b1011, 7'h24, 4);      // E9..E12
        expect_run("scan_m", 4'b0111, 7'h79, 4);      // E13..E16
        expect_run("scan_wrap", 4'b1110, 7'h19, 1);   // E17

        // listo low: new inputs must not be captured.
        drive_digits(4'd9, 4'd9, 4'd9, 4'd9, 1'b0);
        expect_run("hold_u", 4'b1110, 7'h19, 3);      // E18..E20
        expect_run("hold_d", 4'b1101, 7'h30, 4);      // E21..E24
        expect_run("hold_c", 4'b1011, 7'h24, 1);      // E25

        // Capture during the hundreds slot; dwell is unchanged.
        drive_digits(4'd5, 4'd7, 4'd6, 4'd8, 1'b1);
        expect_run("cap_c_old", 4'b1011, 7'h24, 1);   // E26 captures
        listo = 1'b0;
        expect_run("cap_c_new", 4'b1011, 7'h78, 2);   // E27..E28
        expect_run("cap_m", 4'b0111, 7'h12, 4);       // E29..E32
        expect_run("cap_u", 4'b1110, 7'h00, 1);       // E33

        // Illegal BCD on units, with listo held high across several edges.
        unidades_input = 4'hC;
        listo = 1'b1;
        expect_run("bcd_old", 4'b1110, 7'h00, 1);     // E34 captures C
        expect_run("bcd_dash", 4'b1110, 7'h3F, 1);    // E35
        decenas_input = 4'd9;                          // tracked at E36
        expect_run("bcd_dash2", 4'b1110, 7'h3F, 1);   // E36
        listo = 1'b0;
        expect_run("track_d", 4'b1101, 7'h10, 1);     // E37

        // Decode sweep over 1..15 with all digits equal.
        for (int v = 1; v < 16; v++) begin
            drive_digits(4'(v), 4'(v), 4'(v), 4'(v), 1'b1);
            @(negedge clk);
            @(negedge clk);
            n_cmp++;
            assert (seg_output === seg_tbl[v]) else begin
                n_fail++;
                $error("FAIL sweep_%0d seg_output: got %h expected %h",
                       v, seg_output, seg_tbl[v]);
            end
        end

        // Reset asserted between edges while the hundreds digit is lit.
        drive_digits(4'd0, 4'd0, 4'd4, 4'd2, 1'b1);
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (an_output == 4'b1011) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        assert (found == 1) else begin
            n_fail++;
            $error("FAIL wait_slot2: got found=%0d expected found=1", found);
        end
        #2 rst = 1'b0;
        #1 check("rst_async", 4'hF, 7'h7F);
        expect_run("rst_hold", 4'hF, 7'h7F, 1);

        // Release with 0,0,4,2 on the inputs and listo held high.
        rst = 1'b1;
        expect_run("rel_first", 4'b1110, 7'h40, 1);   // held was reset to 0
        expect_run("rel_u", 4'b1110, 7'h24, 3);
        expect_run("rel_d", 4'b1101, 7'h19, 4);
        expect_run("rel_c", 4'b1011, lz_seg, 4);
        expect_run("rel_m", 4'b0111, lz_seg, 4);
        expect_run("rel_wrap", 4'b1110, 7'h24, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/module_mux_display.md
MODULE_MUX_DISPLAY -- requirements
Module: module_mux_display

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 27000: clock cycles each digit stays lit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port unidades_input, input, 4 bits: BCD units digit from the BCD converter.
REQ-005 SHALL have port decenas_input, input, 4 bits: BCD tens digit.
REQ-006 SHALL have port centenas_input, input, 4 bits: BCD hundreds digit.
REQ-007 SHALL have port millares_input, input, 4 bits: BCD thousands digit.
REQ-008 SHALL have port listo, input, 1 bit: converter-done flag; digits are valid while high.
REQ-009 SHALL have port an_output, output, 4 bits: anode enables, active-low; bit0 = units, bit3 = thousands.
REQ-010 SHALL have port seg_output, output, 7 bits: cathodes, active-low, order {g,f,e,d,c,b,a}.

Function
REQ-011 SHALL capture all four digit inputs into a holding register on every rising clk edge where listo = 1; hold them while listo = 0.
REQ-012 SHALL run a refresh counter 0..REFRESH_DIV-1 that wraps to 0; the wrap cycle advances a 2-bit digit index.
REQ-013 SHALL step the digit index 0 -> 1 -> 2 -> 3 -> 0 (units, tens, hundreds, thousands) and wrap with no idle state.
REQ-014 SHALL register an_output and seg_output; both reflect the index and held digits one cycle after an index or held-digit change, with no intermediate combinational path to the pins.
REQ-015 SHALL drive exactly one an_output bit low per cycle outside reset (index 0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111).
REQ-016 SHALL decode seg_output in hex: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-017 SHALL decode illegal BCD values 10..15 to 7'h3F (dash, only g lit).
REQ-018 SHALL take effect on the next registered output when listo updates the held digits mid-scan; the scan position SHALL NOT be disturbed.
REQ-019 SHALL treat listo held high continuously as a capture on every cycle (transparent tracking).

Reset
REQ-020 SHALL, while rst = 0, force an_output = 4'hF, seg_output = 7'h7F, held digits = 0, refresh counter = 0, index = 0, asynchronously.
REQ-021 SHALL, on rst release, start counting on the first rising edge; the first registered output after release SHALL show units digit 0 (an_output = 4'b1110, seg_output = 7'h40).
REQ-022 SHALL, if rst asserts mid-scan, blank immediately and restart from index 0 on release.

Configuration
REQ-023 SHALL, when LEADING_ZERO_BLANK_EN is defined, blank leading zero digits (seg_output = 7'h7F for that slot, anode still scanned) from thousands down to tens; units SHALL always be displayed.
REQ-024 SHALL, when LEADING_ZERO_BLANK_EN is undefined, display all four digits including zeros.

Verification
REQ-025 SHALL cover: REFRESH_DIV=4, reset, apply 1,2,3,4 (thousands..units) with listo pulsed 1 cycle -> an_output cycles 1110/1101/1011/0111, 4 cycles each; seg_output 19,30,24,79 respectively.
REQ-026 SHALL cover: listo held low, inputs changed to 9,9,9,9 -> seg_output keeps previous digits (no capture).
REQ-027 SHALL cover: unidades_input = 4'hC with listo = 1 -> seg_output = 7'h3F while an_output = 4'b1110.
REQ-028 SHALL cover: value 0,0,4,2 (thousands..units) with LEADING_ZERO_BLANK_EN defined -> thousands/hundreds slots 7'h7F, tens 7'h19, units 7'h24; undefined -> thousands/hundreds slots 7'h40.
REQ-029 SHALL cover: rst driven low mid-digit-2 between clock edges -> an_output = 4'hF and seg_output = 7'h7F immediately; after release first lit slot is units.
REQ-030 SHALL cover: new digits captured while index = 2 -> the hundreds slot shows the new value on the following cycle, with no change to dwell count.
